// File: rtl/prog_loader.sv
`default_nettype none
// prog_loader: byte-stream boot loader that fills instruction memory and releases the CPU.
// Optional trailing XOR check byte when PROG_LOADER_CHKSUM_EN is defined.
module prog_loader #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       MAX_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
`ifdef PROG_LOADER_CHKSUM_EN
    ,S_CHK  = 3'd6
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       sr_q, sr_d;
  logic [31:0]       n_q, n_d;
  logic [31:0]       idx_q, idx_d;
  logic [15:0]       wl_q, wl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic        xfer;
  logic [31:0] shifted;
  logic        restart;

  // rx_ready is registered, so a transfer depends only on the previous cycle's state.
  assign xfer    = rx_valid & rx_ready_q;
  assign shifted = {rx_data, sr_q[31:8]};
  assign restart = load_req &&
                   ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    n_d     = n_q;
    idx_d   = idx_q;
    wl_d    = wl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CHKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      S_IDLE: begin
        idx_d  = '0;
        wl_d   = '0;
        bcnt_d = '0;
`ifdef PROG_LOADER_CHKSUM_EN
        chk_d  = '0;
`endif
      end

      S_HDR: begin
        if (xfer) begin
          sr_d   = shifted;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            n_d = shifted;
            if (shifted == 32'd0)
              state_d = S_DONE;
            else if (shifted > 32'(MAX_WORDS))
              state_d = S_ERR;
            else
              state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          sr_d   = shifted;
          bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_LOADER_CHKSUM_EN
          chk_d  = chk_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            wdata_d = shifted;
            // Byte address wraps at ADDR_W bits; BASE_ADDR is assumed word aligned.
            addr_d  = BASE_ADDR + ADDR_W'({idx_q, 2'b00});
          end
        end
      end

      S_WRITE: begin
        idx_d = idx_q + 32'd1;
        wl_d  = wl_q + 16'd1;
        if ((idx_q + 32'd1) == n_q) begin
`ifdef PROG_LOADER_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef PROG_LOADER_CHKSUM_EN
      S_CHK: begin
        if (xfer)
          state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
`endif

      S_DONE, S_ERR: ;

      default: state_d = S_IDLE;
    endcase

    // A new load always starts from a clean count, whatever state it came from.
    if (restart) begin
      state_d = S_HDR;
      idx_d   = '0;
      wl_d    = '0;
      bcnt_d  = '0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_d   = '0;
`endif
    end
  end

  // Output flags are precomputed from the next state so they are glitch-free registers.
  always_comb begin
    rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef PROG_LOADER_CHKSUM_EN
                 || (state_d == S_CHK)
`endif
                 ;
    busy_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WRITE)
`ifdef PROG_LOADER_CHKSUM_EN
                 || (state_d == S_CHK)
`endif
                 ;
    we_d       = (state_d == S_WRITE);
    start_d    = (state_d == S_DONE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      sr_q       <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      wl_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sr_q       <= sr_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      wl_q       <= wl_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PROG_LOADER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_start    = start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = wl_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// tb_prog_loader: scoreboard bench for prog_loader; also exercises PROG_LOADER_CHKSUM_EN when defined.
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic        load_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  prog_loader #(.ADDR_W(32), .MAX_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_start    (cpu_start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          wr_cnt = 0;
  logic [63:0] sb_q[$];
  logic [7:0]  sb_xor;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write strobe is popped against the scoreboard.
  always @(negedge clk) begin
    if (rst && imem_we) begin
      logic [63:0] e;
      wr_cnt++;
      check_val("rdy_in_write", {63'd0, rx_ready}, 64'd0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_write", {32'd0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check_val("wr_addr", {32'd0, imem_addr}, {32'd0, e[63:32]});
        check_val("wr_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Offers one byte; gapped mode offers it for 1 cycle then idles 3 until taken.
  task automatic send_byte(input logic [7:0] b, input bit gapped);
    int  k;
    bit  acc;
    rx_data = b;
    if (!gapped) begin
      rx_valid = 1'b1;
      k = 0;
      while (!rx_ready && k < 100) begin
        tick();
        k++;
      end
      if (!rx_ready) check_val("rx_timeout", 64'd0, 64'd1);
      tick();
    end else begin
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 100) begin
        rx_valid = 1'b1;
        acc = rx_ready;
        tick();
        rx_valid = 1'b0;
        repeat (3) tick();
        k++;
      end
      if (!acc) check_val("rx_gap_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic send_hdr(input logic [31:0] n, input bit gapped);
    sb_xor = 8'h00;
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gapped);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit gapped);
    sb_q.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      sb_xor = sb_xor ^ w[8*i +: 8];
      send_byte(w[8*i +: 8], gapped);
    end
  endtask

  task automatic finish_image(input bit gapped);
`ifdef PROG_LOADER_CHKSUM_EN
    send_byte(sb_xor, gapped);
`else
    if (gapped) tick();
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_flag(input bit want_err, input string tag);
    int k = 0;
    while (!(want_err ? err : done) && k < 200) begin
      tick();
      k++;
    end
    check_val(tag, {63'd0, (want_err ? err : done)}, 64'd1);
  endtask

  initial begin
    int wr0;
    rst      = 1'b0;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    sb_xor   = 8'h00;
    repeat (3) tick();
    check_val("rst_cpu_start", {63'd0, cpu_start}, 64'd0);
    check_val("rst_flags", {60'd0, busy, done, err, rx_ready}, 64'd0);
    check_val("rst_we_wl", {47'd0, imem_we, words_loaded}, 64'd0);
    #2 rst = 1'b1;
    tick();

    // Two-word image with rx_valid held high.
    pulse_load();
    check_val("t1_busy", {63'd0, busy}, 64'd1);
    send_hdr(32'd2, 1'b0);
    send_word(32'h0, 32'h0000_0013, 1'b0);
    send_word(32'h4, 32'h0010_0093, 1'b0);
    finish_image(1'b0);
    wait_flag(1'b0, "t1_done");
    check_val("t1_cpu_start", {63'd0, cpu_start}, 64'd1);
    check_val("t1_words", {48'd0, words_loaded}, 64'd2);
    check_val("t1_wr_cnt", wr_cnt, 64'd2);
    check_val("t1_sb_empty", sb_q.size(), 64'd0);

    // Reload from DONE re-resets the CPU on the same edge.
    pulse_load();
    check_val("t2_cpu_fall", {62'd0, cpu_start, done}, 64'd0);
    check_val("t2_busy_wl", {47'd0, busy, words_loaded}, {47'd0, 1'b1, 16'd0});
    wr0 = wr_cnt;
    send_hdr(32'd0, 1'b0);
    rx_valid = 1'b0;
    wait_flag(1'b0, "t2_done");
    check_val("t2_cpu_start", {63'd0, cpu_start}, 64'd1);
    check_val("t2_no_write", wr_cnt, wr0);

    // Oversized header.
    pulse_load();
    send_hdr(32'd257, 1'b0);
    wait_flag(1'b1, "t3_err");
    check_val("t3_cpu_start", {62'd0, cpu_start, done}, 64'd0);
    repeat (3) tick();
    check_val("t3_hold", {61'd0, err, rx_ready, busy}, 64'd4);
    rx_valid = 1'b0;
    check_val("t3_no_write", wr_cnt, wr0);
    pulse_load();
    check_val("t3_reload", {62'd0, busy, err}, 64'd2);

    // Gapped single-word image, already in HDR.
    send_hdr(32'd1, 1'b1);
    send_word(32'h0, 32'hDEAD_BEEF, 1'b1);
    finish_image(1'b1);
    wait_flag(1'b0, "t4_done");
    check_val("t4_words", {48'd0, words_loaded}, 64'd1);
    check_val("t4_sb_empty", sb_q.size(), 64'd0);

    // Asynchronous reset mid-word.
    pulse_load();
    send_hdr(32'd1, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    wr0 = wr_cnt;
    #2 rst = 1'b0;
    #1;
    check_val("t5_async_flags", {58'd0, busy, done, err, rx_ready, imem_we, cpu_start}, 64'd0);
    check_val("t5_async_data", {imem_addr, imem_wdata}, 64'd0);
    check_val("t5_async_wl", {48'd0, words_loaded}, 64'd0);
    tick();
    #2 rst = 1'b1;
    rx_valid = 1'b1;
    repeat (6) tick();
    check_val("t5_idle", {61'd0, busy, rx_ready, done}, 64'd0);
    check_val("t5_no_write", wr_cnt, wr0);
    rx_valid = 1'b0;

    // Post-reset load (with good check byte when enabled).
    pulse_load();
    send_hdr(32'd1, 1'b0);
    send_word(32'h0, 32'h0000_0013, 1'b0);
    finish_image(1'b0);
    wait_flag(1'b0, "t6_done");
    check_val("t6_cpu_start", {63'd0, cpu_start}, 64'd1);
`ifdef PROG_LOADER_CHKSUM_EN
    pulse_load();
    send_hdr(32'd1, 1'b0);
    send_word(32'h0, 32'h0000_0013, 1'b0);
    send_byte(8'h12, 1'b0);
    rx_valid = 1'b0;
    wait_flag(1'b1, "t7_chk_err");
    check_val("t7_cpu_start", {63'd0, cpu_start}, 64'd0);
`endif
    check_val("final_sb_empty", sb_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle CPU and its instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words into the instruction memory write port.
- Holds the CPU in reset through `cpu_start` until a complete, valid image has been loaded.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- MAX_WORDS, 256, largest accepted image in words; larger header counts are rejected.
- BASE_ADDR, 0, byte address of the first loaded word; must be 4-byte aligned.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- load_req  in  1  single-cycle request to start a load; honoured only in IDLE, DONE, ERR.
- rx_valid  in  1  a byte is offered on rx_data.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts rx_data this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  byte address of the word being written.
- imem_wdata  out  32  word being written.
- cpu_start  out  1  drives the CPU start input; 0 holds the CPU in reset.
- busy  out  1  high in HDR, DATA, WRITE (and CHK).
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- words_loaded  out  16  count of words written in the current load.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output 0, including cpu_start; internal count, index and shift register are cleared.
- Byte transfer: occurs on a rising edge with rx_valid=1 and rx_ready=1. rx_ready is a registered function of state: 1 in HDR, DATA and CHK; 0 elsewhere.
- IDLE:
  - load_req=1 moves to HDR.
  - Clears words_loaded, the index and the checksum.
- HDR:
  - Accepts 4 bytes, little-endian (first byte = bits 7:0), forming a 32-bit word count N.
  - After the 4th byte: N==0 goes to DONE; N>MAX_WORDS goes to ERR; otherwise goes to DATA.
- DATA:
  - Accepts 4 bytes, little-endian, into the shift register.
  - The 4th accepted byte moves to WRITE on the next edge.
- WRITE (exactly one cycle):
  - imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*index with ADDR_W-bit wrap.
  - On exit, index and words_loaded increment.
  - If the new index==N: go to DONE (or CHK when the feature is compiled in). Otherwise return to DATA.
- Latency: the write strobe asserts 1 cycle after the 4th byte of a word is accepted. The 5th byte cannot be accepted before the 2nd cycle after the 4th.
- DONE: cpu_start=1, done=1. load_req=1 returns to HDR on the next edge, and cpu_start falls that same edge, re-resetting the CPU.
- ERR: err=1, cpu_start=0; the state is held until load_req=1, which goes to HDR and clears err.
- Ignored inputs:
  - load_req is ignored in HDR, DATA, WRITE and CHK.
  - rx_valid is ignored whenever rx_ready=0.
- imem_addr and imem_wdata hold their last value when imem_we=0.
- Reset asserted mid-load aborts immediately to IDLE. Partially written memory contents are not cleaned.
- Outputs are registered; no combinational path from rx_valid to rx_ready.

Optional Feature:
- Macro: PROG_LOADER_CHKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every data byte (header excluded).
  - After the last WRITE the FSM enters CHK and accepts one byte.
  - A byte equal to the running XOR goes to DONE; a mismatch goes to ERR.
  - N==0 still goes straight to DONE, with no CHK byte.
- Undefined: no CHK state and no checksum register; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then load_req, then bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 with rx_valid held high:
  - Two imem_we pulses: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093.
  - Then done=1, cpu_start=1, words_loaded=2.
- Header 00 00 00 00 -> DONE with no imem_we pulse and cpu_start=1.
- Header 01 01 00 00 (N=257 > 256) -> err=1, cpu_start=0, no writes. A following load_req -> busy=1, err=0.
- rx_valid gapped (1 cycle on, 3 cycles off) over a 1-word image -> identical write (addr 0, correct data). rx_ready never accepts while in WRITE.
- Reset pulsed low after 2 data bytes of the first word -> all outputs 0 asynchronously. After release the loader stays in IDLE ignoring rx_valid until load_req.
- With PROG_LOADER_CHKSUM_EN, 1-word image 13 00 00 00:
  - Check byte 0x13 -> DONE.
  - Check byte 0x12 -> ERR, cpu_start=0.
